instr_fetch: RTL and testbench



---
 rtl/riscv_fetch_pkg.sv | 25 ++
 rtl/fetch_buf.sv | 72 +++++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
// Imported by the fetch buffer and the fetch top level.
package riscv_fetch_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] PC_INC           = 32'd4;
   localparam int          BUF_DEPTH        = 2;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_REDIRECT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, instr} between instruction memory and decode.
// Flush wins over a same-edge push; pop and push may coincide when full.
module fetch_buf
   import riscv_fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic         valid,
   output logic [1:0]   occ
);

   fetch_entry_t ent_q [BUF_DEPTH];
   fetch_entry_t ent_d [BUF_DEPTH];
   logic         rd_ptr_q, rd_ptr_d;
   logic         wr_ptr_q, wr_ptr_d;
   logic [1:0]   occ_q, occ_d;

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      occ_d    = occ_q;
      ent_d    = ent_q;
      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         occ_d    = 2'd0;
      end else begin
         if (push) begin
            ent_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         occ_d = occ_q + {1'b0, push} - {1'b0, pop};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // NOTE: payload storage has no reset; occupancy alone says which entries are live.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   assign head  = ent_q[rd_ptr_q];
   assign valid = (occ_q != 2'd0);
   assign occ   = occ_q;

   overflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(push && !flush && !pop && (occ_q == 2'(BUF_DEPTH))));
   underflow_a: assert property (@(posedge clk) disable iff (!rst)
      !(pop && (occ_q == 2'd0)));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues one-cycle-latency memory reads under
// a buffer credit rule, and redirects/flushes on resolved taken branches.
module instr_fetch
   import riscv_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_rd_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        br_taken,
   input  logic [31:0] br_pc,
   input  logic [31:0] br_imm,
   input  logic        halt,
   output logic        misalign_err
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  rsp_pc_q, rsp_pc_d;
   logic         inflight_q, inflight_d;
   logic         tag_q, tag_d;
   logic         epoch_q, epoch_d;
   logic         misalign_q, misalign_d;

   logic         buf_valid, pop, push, redirect, issue;
   logic [1:0]   occ;
   logic [2:0]   pending;
   logic [31:0]  target;
   fetch_entry_t head, wr_entry;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      rsp_pc_d   = rsp_pc_q;
      inflight_d = 1'b0;
      tag_d      = tag_q;
      epoch_d    = epoch_q;
      misalign_d = misalign_q;

      pop      = buf_valid && instr_ready;
      redirect = (state_q == ST_RUN) && br_taken;
      target   = br_pc + br_imm;
      // Words already owed to the buffer after this cycle's pop; one more read must still fit.
      pending  = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
      // REDIRECT is the target-fetch cycle: it reads but does not take another branch.
      issue    = (state_q != ST_IDLE) && !redirect && !halt && (pending < 3'(BUF_DEPTH));
      push     = inflight_q && (tag_q == epoch_q);

      case (state_q)
         ST_IDLE:     state_d = ST_RUN;
         ST_RUN:      if (br_taken) state_d = ST_REDIRECT;
         ST_REDIRECT: state_d = ST_RUN;
         default:     state_d = ST_IDLE;
      endcase

      if (redirect) begin
         pc_d    = align_word(target);
         epoch_d = ~epoch_q;
         if (target[1:0] != 2'b00) begin
            misalign_d = 1'b1;
         end
      end else if (issue) begin
         pc_d       = pc_q + PC_INC;
         rsp_pc_d   = pc_q;
         inflight_d = 1'b1;
         tag_d      = epoch_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         pc_q       <= RESET_PC;
         rsp_pc_q   <= '0;
         inflight_q <= 1'b0;
         tag_q      <= 1'b0;
         epoch_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         rsp_pc_q   <= rsp_pc_d;
         inflight_q <= inflight_d;
         tag_q      <= tag_d;
         epoch_q    <= epoch_d;
         misalign_q <= misalign_d;
      end
   end

   assign wr_entry = {rsp_pc_q, imem_rdata};

   fetch_buf u_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata (wr_entry),
      .pop   (pop),
      .flush (redirect),
      .head  (head),
      .valid (buf_valid),
      .occ   (occ)
   );

   assign imem_rd_en   = issue;
   assign imem_addr    = pc_q;
   assign instr_valid  = buf_valid;
   assign instr        = buf_valid ? head.instr : INSTR_NOP;
   assign instr_pc     = buf_valid ? head.pc : 32'h0000_0000;
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: the model predicts the delivered stream as
// consecutive words from the last fetch target, with memory data = addr >> 2.
module tb_instr_fetch;
   import riscv_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_rd_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        br_taken = 1'b0;
   logic [31:0] br_pc = '0;
   logic [31:0] br_imm = '0;
   logic        halt = 1'b0;
   logic        misalign_err;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gen_pc;
   logic        model_mis = 1'b0;
   int          n_checks = 0;
   int          n_pass = 0;
   int          n_stream = 0;

   instr_fetch dut (
      .clk          (clk),
      .rst          (rst),
      .imem_rd_en   (imem_rd_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr        (instr),
      .instr_pc     (instr_pc),
      .br_taken     (br_taken),
      .br_pc        (br_pc),
      .br_imm       (br_imm),
      .halt         (halt),
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a >> 2;
   endfunction

   // Synchronous instruction memory with one-cycle read latency.
   always @(posedge clk) begin
      if (imem_rd_en) imem_rdata <= mem_word(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic top_up();
      while (exp_q.size() < 16) begin
         exp_q.push_back({gen_pc, mem_word(gen_pc)});
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   task automatic restart_stream(input logic [31:0] start);
      exp_q.delete();
      gen_pc = start;
      top_up();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      top_up();
   endtask

   // Monitor: every accepted word must be the next one the model predicts.
   always @(negedge clk) begin
      if (rst && instr_valid && instr_ready) begin
         if (exp_q.size() == 0) begin
            check("stream_underflow", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("stream_pc", instr_pc, e.pc);
            check("stream_instr", instr, e.instr);
            n_stream++;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] tgt;
      int          since_br;
      logic        did_br;

      // Reset values
      #3;
      check("rst_valid", instr_valid, 0);
      check("rst_rd_en", imem_rd_en, 0);
      check("rst_instr", instr, INSTR_NOP);
      check("rst_instr_pc", instr_pc, 0);
      check("rst_misalign", misalign_err, 0);
      restart_stream(RESET_PC_DEFAULT);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // First fetch latency
      check("idle_no_issue", imem_rd_en, 0);
      tick();
      check("first_issue", imem_rd_en, 1);
      check("first_addr", imem_addr, 0);
      check("lat_n", instr_valid, 0);
      tick();
      check("lat_n1", instr_valid, 0);
      tick();
      check("lat_n2_valid", instr_valid, 1);
      check("lat_n2_pc", instr_pc, 0);
      repeat (4) tick();

      // Decode stall: head holds, reads stop, stream resumes without gap
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", instr_valid, 1);
         check("stall_head_pc", instr_pc, exp_q[0].pc);
         check("stall_no_issue", imem_rd_en, 0);
      end
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("release_no_gap", instr_valid, 1);
      end

      // Taken branch to 0, then a branch during REDIRECT that must be ignored
      br_taken = 1'b1;
      br_pc    = 32'd8;
      br_imm   = 32'hFFFF_FFF8;
      #1 check("no_issue_in_R", imem_rd_en, 0);
      tick();
      restart_stream(32'd0);
      br_pc = 32'h40;
      br_imm = 32'd2;
      check("r1_issue", imem_rd_en, 1);
      check("r1_addr", imem_addr, 0);
      check("r1_flushed", instr_valid, 0);
      tick();
      br_taken = 1'b0;
      check("r2_valid", instr_valid, 0);
      check("r2_addr", imem_addr, 4);
      check("ignored_br_misalign", misalign_err, 0);
      tick();
      check("r3_valid", instr_valid, 1);
      check("r3_pc", instr_pc, 0);
      repeat (3) tick();

      // Misaligned target
      br_taken = 1'b1;
      br_pc    = 32'd4;
      br_imm   = 32'd6;
      tick();
      br_taken = 1'b0;
      restart_stream(32'd8);
      model_mis = 1'b1;
      check("mis_flag", misalign_err, 1);
      check("mis_addr", imem_addr, 8);
      repeat (5) tick();

      // Halt: no reads, buffer drains, resume at next pc
      halt = 1'b1;
      #1 check("halt_no_issue", imem_rd_en, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("halt_no_issue", imem_rd_en, 0);
      end
      check("halt_drained", instr_valid, 0);
      halt = 1'b0;
      #1;
      check("halt_resume_issue", imem_rd_en, 1);
      check("halt_resume_addr", imem_addr, exp_q[0].pc);
      tick();

      // Randomized traffic
      since_br = 10;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         instr_ready = ($urandom_range(0, 3) != 0);
         halt        = ($urandom_range(0, 9) < 2);
         did_br      = 1'b0;
         if (since_br >= 2 && $urandom_range(0, 7) == 0) begin
            br_pc  = 32'($urandom_range(0, 255)) << 2;
            br_imm = 32'($urandom_range(0, 63)) * 32'd4 - 32'd128;
            if ($urandom_range(0, 5) == 0) br_imm = br_imm + 32'($urandom_range(1, 3));
            br_taken = 1'b1;
            did_br   = 1'b1;
         end
         #1;
         if (halt || br_taken) check("rand_no_issue", imem_rd_en, 0);
         tick();
         br_taken = 1'b0;
         if (did_br) begin
            tgt = br_pc + br_imm;
            restart_stream({tgt[31:2], 2'b00});
            if (tgt[1:0] != 2'b00) model_mis = 1'b1;
            since_br = 0;
         end else begin
            since_br++;
         end
         check("rand_misalign", misalign_err, model_mis);
      end
      halt = 1'b0;
      instr_ready = 1'b1;
      repeat (4) tick();

      // Asynchronous reset with a full buffer
      instr_ready = 1'b0;
      repeat (3) tick();
      check("pre_rst_valid", instr_valid, 1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_valid", instr_valid, 0);
      check("async_rst_instr", instr, INSTR_NOP);
      check("async_rst_pc", instr_pc, 0);
      check("async_rst_mis", misalign_err, 0);
      check("async_rst_rd_en", imem_rd_en, 0);
      restart_stream(RESET_PC_DEFAULT);
      model_mis = 1'b0;
      instr_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b1;
      repeat (3) tick();
      check("restart_valid", instr_valid, 1);
      check("restart_pc", instr_pc, 0);
      repeat (20) tick();
      check("stream_activity", (n_stream >= 300) ? 32'd1 : 32'd0, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
